// File: rtl/uart_frame_counter.sv
// uart_frame_counter
//   Tracks bit position inside one UART frame: start bit, D data bits,
//   an optional parity bit, and one or two stop bits. Configuration is
//   latched on an accepted start. The counter advances on each tick.
//
//   Optional feature macro: UART_FRAME_COUNTER_OVERRUN_EN adds the
//   overrun output (sticky flag for a start seen while a frame is active).
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      begin a frame and latch data_bits / parity_en / two_stop
//   tick       one bit period elapsed (advance strobe)
//   data_bits  requested data-bit count, clamped to 5..MAX_DATA
//   parity_en  parity bit present
//   two_stop   two stop bits instead of one
//   busy       frame in progress
//   bit_cnt    current bit position within the frame
//   phase      00 start, 01 data, 10 parity, 11 stop
//   data_idx   data bit index during the data phase, else 0
//   last_bit   bit_cnt is the final position of the frame
//   done       one-cycle pulse after the final tick
//   overrun    (macro only) start seen while active, sticky until next start
module uart_frame_counter #(
    parameter int MAX_DATA = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             tick,
    input  logic [3:0]       data_bits,
    input  logic             parity_en,
    input  logic             two_stop,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] data_idx,
    output logic             last_bit,
`ifdef UART_FRAME_COUNTER_OVERRUN_EN
    output logic             done,
    output logic             overrun
`else
    output logic             done
`endif
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state;
    logic [CNT_W-1:0] d_lat;
    logic             par_lat;
    logic             two_lat;
    logic [CNT_W-1:0] last_pos;

    function automatic logic [CNT_W-1:0] clamp_bits(input logic [3:0] v);
        if (int'(v) < 5)
            return CNT_W'(5);
        if (int'(v) > MAX_DATA)
            return CNT_W'(MAX_DATA);
        return CNT_W'(v);
    endfunction

    // L-1 = D + parity + stop bits (the start bit occupies position 0)
    assign last_pos = d_lat + CNT_W'(par_lat) + (two_lat ? CNT_W'(2) : CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            done    <= 1'b0;
            d_lat   <= CNT_W'(8);
            par_lat <= 1'b0;
            two_lat <= 1'b0;
`ifdef UART_FRAME_COUNTER_OVERRUN_EN
            overrun <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // a tick in the same cycle as start is dropped
                    if (start) begin
                        d_lat   <= clamp_bits(data_bits);
                        par_lat <= parity_en;
                        two_lat <= two_stop;
                        bit_cnt <= '0;
                        state   <= ACTIVE;
`ifdef UART_FRAME_COUNTER_OVERRUN_EN
                        overrun <= 1'b0;
`endif
                    end
                end
                ACTIVE: begin
`ifdef UART_FRAME_COUNTER_OVERRUN_EN
                    if (start)
                        overrun <= 1'b1;
`endif
                    if (tick) begin
                        if (bit_cnt == last_pos) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                            done    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Field decode uses only registered state, so no input reaches these outputs.
    assign busy     = (state == ACTIVE);
    assign last_bit = busy && (bit_cnt == last_pos);

    always_comb begin
        phase = 2'b11;
        if (bit_cnt == '0)
            phase = 2'b00;
        else if (bit_cnt <= d_lat)
            phase = 2'b01;
        else if (par_lat && (bit_cnt == d_lat + CNT_W'(1)))
            phase = 2'b10;
    end

    assign data_idx = (phase == 2'b01) ? bit_cnt - CNT_W'(1) : '0;

endmodule

// File: tb/tb_uart_frame_counter.sv
module tb_uart_frame_counter;

    localparam int MAX_DATA = 8;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             tick;
    logic [3:0]       data_bits;
    logic             parity_en;
    logic             two_stop;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic [1:0]       phase;
    logic [CNT_W-1:0] data_idx;
    logic             last_bit;
    logic             done;
`ifdef UART_FRAME_COUNTER_OVERRUN_EN
    logic             overrun;
    bit               ovr_exp;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    uart_frame_counter #(.MAX_DATA(MAX_DATA), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tick      (tick),
        .data_bits (data_bits),
        .parity_en (parity_en),
        .two_stop  (two_stop),
        .busy      (busy),
        .bit_cnt   (bit_cnt),
        .phase     (phase),
        .data_idx  (data_idx),
        .last_bit  (last_bit),
`ifdef UART_FRAME_COUNTER_OVERRUN_EN
        .done      (done),
        .overrun   (overrun)
`else
        .done      (done)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference frame layout: list of field codes, one per bit position.
    task automatic build_frame(input int db, input bit par, input bit two,
                               output int fields[$]);
        int d;
        d = (db < 5) ? 5 : ((db > MAX_DATA) ? MAX_DATA : db);
        fields = {};
        fields.push_back(0);
        repeat (d) fields.push_back(1);
        if (par) fields.push_back(2);
        repeat (two ? 2 : 1) fields.push_back(3);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},     busy,     0);
        chk({tag, ".bit_cnt"},  bit_cnt,  0);
        chk({tag, ".phase"},    phase,    0);
        chk({tag, ".data_idx"}, data_idx, 0);
        chk({tag, ".last_bit"}, last_bit, 0);
        chk({tag, ".done"},     done,     0);
`ifdef UART_FRAME_COUNTER_OVERRUN_EN
        chk({tag, ".overrun"},  overrun,  ovr_exp);
`endif
    endtask

    task automatic chk_pos(input string tag, input int k, input int fields[$]);
        int L;
        L = fields.size();
        chk({tag, ".busy"},     busy,     1);
        chk({tag, ".bit_cnt"},  bit_cnt,  k);
        chk({tag, ".phase"},    phase,    fields[k]);
        chk({tag, ".data_idx"}, data_idx, (fields[k] == 1) ? k - 1 : 0);
        chk({tag, ".last_bit"}, last_bit, (k == L - 1) ? 1 : 0);
        chk({tag, ".done"},     done,     0);
`ifdef UART_FRAME_COUNTER_OVERRUN_EN
        chk({tag, ".overrun"},  overrun,  ovr_exp);
`endif
    endtask

    // One full frame; returns in the done cycle so the caller's next start
    // lands in that cycle.
    task automatic do_frame(input int db, input bit par, input bit two,
                            input bit same_tick, input bit noisy);
        int fields[$];
        int L;
        build_frame(db, par, two, fields);
        L = fields.size();
        start = 1'b1; tick = same_tick;
        data_bits = 4'(db); parity_en = par; two_stop = two;
        step();
        start = 1'b0; tick = 1'b0;
`ifdef UART_FRAME_COUNTER_OVERRUN_EN
        ovr_exp = 1'b0;
`endif
        chk_pos("start", 0, fields);
        for (int k = 1; k <= L; k++) begin
            if (noisy) begin
                repeat ($urandom_range(0, 2)) begin
                    data_bits = 4'($urandom);
                    parity_en = 1'($urandom);
                    two_stop  = 1'($urandom);
                    start     = ($urandom_range(0, 3) == 0);
                    step();
`ifdef UART_FRAME_COUNTER_OVERRUN_EN
                    if (start) ovr_exp = 1'b1;
`endif
                    start = 1'b0;
                    chk_pos("hold", k - 1, fields);
                end
            end
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (k < L) begin
                chk_pos("tick", k, fields);
            end else begin
                chk("end.done",    done,    1);
                chk("end.busy",    busy,    0);
                chk("end.bit_cnt", bit_cnt, 0);
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; tick = 1'b0;
        data_bits = 4'd8; parity_en = 1'b0; two_stop = 1'b0;
`ifdef UART_FRAME_COUNTER_OVERRUN_EN
        ovr_exp = 1'b0;
`endif
        #12;
        chk_idle("rst");
        reset = 1'b1;
        step();
        chk_idle("post_rst");

        // Idle ticks are ignored.
        tick = 1'b1; step(); tick = 1'b0;
        chk_idle("idle_tick");

        // 8N1, 7E2, clamped low and high, start+tick together.
        do_frame(8, 1'b0, 1'b0, 1'b0, 1'b0);
        do_frame(7, 1'b1, 1'b1, 1'b0, 1'b0);
        do_frame(3, 1'b0, 1'b0, 1'b0, 1'b0);
        do_frame(15, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        chk_idle("one_shot_done");

        // Randomized frames with noise, back-to-back or idle-separated.
        for (int f = 0; f < 40; f++) begin
            do_frame(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                tick = 1'($urandom);
                step();
                tick = 1'b0;
                chk_idle("gap");
            end
        end

        // Reset mid-frame at bit_cnt 5: outputs clear at once, no done.
        start = 1'b1; data_bits = 4'd8; step(); start = 1'b0;
        repeat (5) begin tick = 1'b1; step(); end
        tick = 1'b0;
        chk("pre_rst.bit_cnt", bit_cnt, 5);
        reset = 1'b0;
        #1;
`ifdef UART_FRAME_COUNTER_OVERRUN_EN
        ovr_exp = 1'b0;
`endif
        chk_idle("mid_rst");
        tick = 1'b1;
        step(); step();
        tick = 1'b0;
        chk_idle("rst_hold");
        #2 reset = 1'b1;
        start = 1'b1; data_bits = 4'd5;
        step();
        start = 1'b0;
        chk("rst_start.busy",    busy,    1);
        chk("rst_start.bit_cnt", bit_cnt, 0);
        step();
        chk("rst_no_done", done, 0);

`ifdef UART_FRAME_COUNTER_OVERRUN_EN
        // start at bit_cnt 3 sets overrun; next accepted start clears it.
        repeat (3) begin tick = 1'b1; step(); end
        tick = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("ovr_set", overrun, 1);
        repeat (4) begin tick = 1'b1; step(); end
        tick = 1'b0;
        chk("ovr_done", done, 1);
        chk("ovr_sticky", overrun, 1);
        start = 1'b1; step(); start = 1'b0;
        chk("ovr_clear", overrun, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_counter.md
UART_FRAME_COUNTER -- requirements
Module: uart_frame_counter

Interface
REQ-001 SHALL provide parameter MAX_DATA, default 8, meaning the largest data-bit count accepted (legal range 5..9).
REQ-002 SHALL provide parameter CNT_W, default 4, meaning the counter width; CNT_W SHALL be able to hold MAX_DATA+3.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1, request to begin a frame; it also latches the configuration.
REQ-006 SHALL have port tick, input, 1, one bit period elapsed; this is the advance strobe.
REQ-007 SHALL have port data_bits, input, 4, requested data-bit count.
REQ-008 SHALL have port parity_en, input, 1, parity bit present in the frame.
REQ-009 SHALL have port two_stop, input, 1, two stop bits instead of one.
REQ-010 SHALL have port busy, output, 1, a frame is in progress.
REQ-011 SHALL have port bit_cnt, output, CNT_W, current frame bit position.
REQ-012 SHALL have port phase, output, 2, current field: 00 start, 01 data, 10 parity, 11 stop.
REQ-013 SHALL have port data_idx, output, CNT_W, data bit index in the data phase; 0 otherwise.
REQ-014 SHALL have port last_bit, output, 1, bit_cnt equals L-1 while busy.
REQ-015 SHALL have port done, output, 1, one-cycle frame-complete pulse.

Function
REQ-016 SHALL use two states: IDLE and ACTIVE.
REQ-017 In IDLE, start SHALL do all of the following on the next edge:
- latch the clamped data_bits value D, parity_en and two_stop;
- set bit_cnt to 0;
- enter ACTIVE.
REQ-018 D SHALL be data_bits clamped to 5..MAX_DATA: values below 5 become 5; values above MAX_DATA become MAX_DATA.
REQ-019 The frame length SHALL be L = 1 + D + parity_en + (two_stop ? 2 : 1), computed from the latched values only.
REQ-020 In ACTIVE, tick SHALL increment bit_cnt when bit_cnt < L-1.
REQ-021 In ACTIVE, tick SHALL end the frame when bit_cnt == L-1: bit_cnt goes to 0, the state goes to IDLE, and done is high for exactly the following cycle.
REQ-022 tick in IDLE SHALL be ignored.
REQ-023 When start and tick are high in the same IDLE cycle, start SHALL be taken and tick ignored, so the first counted tick is a later one.
REQ-024 start while ACTIVE SHALL be ignored, and the latched configuration SHALL remain unchanged.
REQ-025 A start arriving in the cycle that done is high SHALL be accepted.
REQ-026 phase SHALL decode from bit_cnt and the latched configuration:
- 0 is start;
- 1..D is data;
- D+1 is parity when parity is enabled;
- the remaining positions are stop.
REQ-027 data_idx SHALL equal bit_cnt-1 in the data phase.
REQ-028 busy, phase, data_idx and last_bit SHALL be registered or derived only from registers, with no combinational path from the inputs.
REQ-029 Live changes on data_bits, parity_en or two_stop during ACTIVE SHALL NOT affect the current frame.

Reset
REQ-030 While reset is low, the block SHALL asynchronously hold:
- the state at IDLE;
- bit_cnt, data_idx, phase, last_bit, busy and done at 0;
- the latched configuration at D=8, no parity, one stop bit.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no done pulse.
REQ-032 After reset is released, the block SHALL accept start on the first clk edge.

Configuration
REQ-033 With macro UART_FRAME_COUNTER_OVERRUN_EN defined, output overrun (1 bit) SHALL exist.
REQ-034 overrun SHALL set when start is high while ACTIVE, and SHALL stay set until the next accepted start or reset.
REQ-035 Without the macro, the overrun port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Config data_bits=8, no parity, one stop; start, then 10 ticks -> bit_cnt runs 0..9, phase sequence 00, 01x8, 11, then done pulses once and busy falls.
REQ-037 Config data_bits=7, parity on, two stops; L=11 -> phase 10 at bit_cnt=8, phase 11 at 9..10, done after the 11th tick.
REQ-038 data_bits=3 -> D=5 and L=7; data_bits=15 with MAX_DATA=8 -> D=8.
REQ-039 start and tick in the same cycle, then data_bits changed mid-frame -> the first tick is ignored and L is unchanged; start in the done cycle -> a new frame begins with bit_cnt=0.
REQ-040 Reset pulse at bit_cnt=5 -> all outputs 0 and no done; with the macro defined, start at bit_cnt=3 -> overrun=1, cleared by the next accepted start.
